chain_ctrl: RTL and testbench

Run/stop/single-step sequencer for the 4-stage display counter chain.
- Debounces four raw board buttons on the 1 ms strobe.
- Gates the count-rate tick into the first stage's ce.
- Issues one-cycle load and clear commands to the chain.
- Sits between the ms/tick generator, the buttons and the counter chain; replaces the bare two-FF edge detectors.

---
 rtl/chain_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/chain_ctrl.sv | 139 +++++++++++++
 tb/tb_chain_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_ctrl_pkg.sv
// Shared definitions for the display counter-chain run/stop/step sequencer.
//   state_e : FSM state codes, also driven out on chain_ctrl.state
//   B_*     : bit index of each board button inside the 4-bit button bus
package chain_ctrl_pkg;

  typedef enum logic [2:0] {
    S_STOP  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_LOAD  = 3'd3,
    S_CLEAR = 3'd4
  } state_e;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned B_RUN   = 0;
  localparam int unsigned B_STEP  = 1;
  localparam int unsigned B_LOAD  = 2;
  localparam int unsigned B_CLR   = 3;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, ms-strobe debounce counter and
// rising-edge press pulse.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   ce1ms_i : one-clk strobe every 1 ms
//   btn_i   : raw asynchronous button level
//   press_o : one-clk pulse when the debounced level rises
module btn_debounce #(
  parameter int unsigned DB_MS = 8,
  parameter int unsigned DB_W  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce1ms_i,
  input  logic btn_i,
  output logic press_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synced level disagrees with the
  // debounced level; any agreement in between restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (ce1ms_i) begin
      if (cnt_q == DB_W'(DB_MS - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/chain_ctrl.sv
// Run/stop/single-step sequencer for the 4-stage display counter chain.
// Debounces the four board buttons, gates the count-rate tick into the first
// stage's ce and issues one-clk load/clear commands.
//   clk        : system clock
//   R          : synchronous active-high reset
//   ce1ms      : 1 ms strobe for the debouncers
//   tick       : count-rate strobe
//   btn        : raw buttons [0] run/stop, [1] step, [2] load, [3] clear
//   stop_on_tc : auto-stop when the chain wraps
//   ceo_chain  : last-stage carry out (chain wrap)
//   ce_out     : ce to first chain stage (combinational tick gate)
//   load_out   : parallel-load command, one clk
//   clr_out    : clear command, one clk
//   running    : high while in RUN
//   state      : current state code
//   wrap_flag  : sticky chain-wrapped indicator, cleared by CLEAR
module chain_ctrl
  import chain_ctrl_pkg::*;
#(
  parameter int unsigned DB_MS = 8,
  parameter int unsigned DB_W  = 4
) (
  input  logic       clk,
  input  logic       R,
  input  logic       ce1ms,
  input  logic       tick,
  input  logic [3:0] btn,
  input  logic       stop_on_tc,
  input  logic       ceo_chain,
  output logic       ce_out,
  output logic       load_out,
  output logic       clr_out,
  output logic       running,
  output logic [2:0] state,
  output logic       wrap_flag
);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] win;
  state_e             state_q, state_d;
  logic               resume_q, resume_d;
  logic               wrap_q, wrap_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(
      .DB_MS(DB_MS),
      .DB_W (DB_W)
    ) u_db (
      .clk_i  (clk),
      .rst_i  (R),
      .ce1ms_i(ce1ms),
      .btn_i  (btn[g]),
      .press_o(press[g])
    );
  end

  // Only the highest-priority press of a cycle survives; a surviving press
  // that the current state ignores does not let a lower one through.
  always_comb begin
    win = '0;
    if (press[B_CLR])       win[B_CLR]  = 1'b1;
    else if (press[B_LOAD]) win[B_LOAD] = 1'b1;
    else if (press[B_STEP]) win[B_STEP] = 1'b1;
    else if (press[B_RUN])  win[B_RUN]  = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    ce_out   = 1'b0;
    case (state_q)
      S_STOP: begin
        if (win[B_CLR]) begin
          state_d = S_CLEAR;
        end else if (win[B_LOAD]) begin
          state_d  = S_LOAD;
          resume_d = 1'b0;
        end else if (win[B_STEP]) begin
          state_d = S_STEP;
        end else if (win[B_RUN]) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Gate uses the current state, so a tick in the leaving clk still counts.
        ce_out = tick;
        if (win[B_CLR]) begin
          state_d = S_CLEAR;
        end else if (win[B_LOAD]) begin
          state_d  = S_LOAD;
          resume_d = 1'b1;
        end else if (win[B_RUN]) begin
          state_d = S_STOP;
        end else if (ceo_chain && stop_on_tc) begin
          state_d = S_STOP;
        end
      end
      S_STEP: begin
        if (win[B_CLR]) begin
          state_d = S_CLEAR;
        end else if (win[B_LOAD]) begin
          state_d  = S_LOAD;
          resume_d = 1'b0;
        end else if (tick) begin
          ce_out  = 1'b1;
          state_d = S_STOP;
        end
      end
      S_LOAD:  state_d = resume_q ? S_RUN : S_STOP;
      S_CLEAR: state_d = S_STOP;
      default: state_d = S_STOP;
    endcase
  end

  always_comb begin
    wrap_d = wrap_q;
    if (state_q == S_CLEAR) wrap_d = 1'b0;
    else if (ceo_chain)     wrap_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q  <= S_STOP;
      resume_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      wrap_q   <= wrap_d;
    end
  end

  assign load_out  = (state_q == S_LOAD);
  assign clr_out   = (state_q == S_CLEAR);
  assign running   = (state_q == S_RUN);
  assign state     = state_q;
  assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_chain_ctrl.sv
module tb_chain_ctrl;

  localparam int DBMS = 2;

  logic       clk = 1'b0;
  logic       R;
  logic       ce1ms;
  logic       tick;
  logic [3:0] btn;
  logic       stop_on_tc;
  logic       ceo_chain;
  logic       ce_out, load_out, clr_out, running, wrap_flag;
  logic [2:0] state;

  logic wrap_en;
  logic rand_ceo;
  logic rnd_ceo_en;

  int checks = 0;
  int errors = 0;

  assign ceo_chain = wrap_en ? ce_out : rand_ceo;

  chain_ctrl #(.DB_MS(DBMS), .DB_W(4)) dut (
    .clk       (clk),
    .R         (R),
    .ce1ms     (ce1ms),
    .tick      (tick),
    .btn       (btn),
    .stop_on_tc(stop_on_tc),
    .ceo_chain (ceo_chain),
    .ce_out    (ce_out),
    .load_out  (load_out),
    .clr_out   (clr_out),
    .running   (running),
    .state     (state),
    .wrap_flag (wrap_flag)
  );

  always #5 clk = ~clk;

  // strobe generation: ce1ms every 10 clk, tick every 25 clk
  initial begin
    int cyc;
    cyc = 0;
    ce1ms = 1'b0; tick = 1'b0; rand_ceo = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      ce1ms    = (cyc % 10 == 0);
      tick     = (cyc % 25 == 0);
      rand_ceo = rnd_ceo_en && ($urandom_range(0, 7) == 0);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int st;
    bit ce, ld, cl, run, wr;
  } exp_t;
  exp_t exp_q[$];

  bit live = 0;
  int m_st, m_res, m_wrap;
  int sy1[4], sy2[4], deb[4], dcnt[4], prs[4];
  bit c_R, c_tick, c_ce, c_ceo, c_sot;
  logic [3:0] c_btn;

  function automatic int top_press();
    for (int b = 3; b >= 0; b--) if (prs[b] != 0) return b;
    return -1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int hp;
    c_R = R; c_tick = tick; c_ce = ce1ms; c_ceo = ceo_chain; c_sot = stop_on_tc; c_btn = btn;
    if (live) begin
      hp    = top_press();
      e.st  = m_st;
      e.ld  = (m_st == 3);
      e.cl  = (m_st == 4);
      e.run = (m_st == 1);
      e.wr  = (m_wrap != 0);
      e.ce  = c_tick && (m_st == 1 || (m_st == 2 && hp != 3 && hp != 2));
      exp_q.push_back(e);
    end
  end

  always @(posedge clk) begin
    int hp, nst;
    if (c_R) begin
      live = 1; m_st = 0; m_res = 0; m_wrap = 0;
      for (int b = 0; b < 4; b++) begin
        sy1[b] = 0; sy2[b] = 0; deb[b] = 0; dcnt[b] = 0; prs[b] = 0;
      end
    end else if (live) begin
      hp  = top_press();
      nst = m_st;
      if (m_st == 0) begin
        if (hp == 3) nst = 4;
        else if (hp == 2) begin nst = 3; m_res = 0; end
        else if (hp == 1) nst = 2;
        else if (hp == 0) nst = 1;
      end else if (m_st == 1) begin
        if (hp == 3) nst = 4;
        else if (hp == 2) begin nst = 3; m_res = 1; end
        else if (hp == 0) nst = 0;
        else if (c_ceo && c_sot) nst = 0;
      end else if (m_st == 2) begin
        if (hp == 3) nst = 4;
        else if (hp == 2) begin nst = 3; m_res = 0; end
        else if (c_tick) nst = 0;
      end else if (m_st == 3) begin
        nst = (m_res != 0) ? 1 : 0;
      end else begin
        nst = 0;
      end
      if (m_st == 4) m_wrap = 0;
      else if (c_ceo) m_wrap = 1;
      m_st = nst;
      // debounce: level flips after DBMS strobes of uninterrupted disagreement
      for (int b = 0; b < 4; b++) begin
        bit flip;
        flip = 0;
        if (sy2[b] == deb[b]) dcnt[b] = 0;
        else if (c_ce) dcnt[b] = dcnt[b] + 1;
        if (dcnt[b] >= DBMS) begin flip = 1; deb[b] = sy2[b]; dcnt[b] = 0; end
        prs[b] = (flip && deb[b] == 1) ? 1 : 0;
        sy2[b] = sy1[b];
        sy1[b] = c_btn[b] ? 1 : 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int fail_prints = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state !== 3'(e.st) || ce_out !== e.ce || load_out !== e.ld ||
          clr_out !== e.cl || running !== e.run || wrap_flag !== e.wr) begin
        errors++;
        if (fail_prints < 30) begin
          fail_prints++;
          $display("FAIL outputs @%0t: got st=%0d ce=%b ld=%b cl=%b run=%b wr=%b, want st=%0d ce=%b ld=%b cl=%b run=%b wr=%b",
                   $time, state, ce_out, load_out, clr_out, running, wrap_flag,
                   e.st, e.ce, e.ld, e.cl, e.run, e.wr);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    repeat (40) @(posedge clk);
    #1 btn = 4'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int code, input int budget);
    int n;
    n = 0;
    while (state !== 3'(code) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state_timeout", (state === 3'(code)) ? 1 : 0, 1);
  endtask

  initial begin
    R = 1'b1; btn = 4'b0; stop_on_tc = 1'b0; wrap_en = 1'b0; rnd_ceo_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 R = 1'b0;
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_outs", int'({ce_out, load_out, clr_out, running, wrap_flag}), 0);

    press(4'b0001);
    chk("run_press", int'(state), 1);

    for (int i = 0; i < 20; i++) begin
      btn[0] = ~btn[0];
      repeat (3) @(posedge clk);
      #1;
    end
    btn = 4'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("bounce_no_press", int'(state), 1);

    press(4'b0001);
    chk("run_to_stop", int'(state), 0);
    press(4'b0010);
    chk("step_done", int'(state), 0);

    press(4'b0001);
    press(4'b0100);
    chk("load_resume_run", int'(state), 1);
    press(4'b0001);
    press(4'b0100);
    chk("load_from_stop", int'(state), 0);

    stop_on_tc = 1'b1;
    wrap_en    = 1'b1;
    press(4'b0001);
    wait_state(0, 200);
    chk("wrap_flag_set", int'(wrap_flag), 1);
    wrap_en = 1'b0;
    press(4'b1000);
    chk("clear_wrap", int'(wrap_flag), 0);
    chk("clear_state", int'(state), 0);

    press(4'b1010);
    chk("clr_beats_step", int'(state), 0);

    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      stop_on_tc = $urandom_range(0, 1) != 0;
      wrap_en    = $urandom_range(0, 3) == 0;
      rnd_ceo_en = $urandom_range(0, 2) == 0;
      if (sel == 9) btn = 4'($urandom);
      else btn = 4'b0001 << (sel % 4);
      repeat ($urandom_range(5, 45)) @(posedge clk);
      #1 btn = 4'b0;
      if ($urandom_range(0, 19) == 0) begin
        R = 1'b1;
        repeat (2) @(posedge clk);
        #1 R = 1'b0;
      end
      repeat ($urandom_range(0, 45)) @(posedge clk);
      #1;
    end

    repeat (60) @(posedge clk);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
